counter_ctrl: RTL and testbench

Run-mode sequencer for a programmable modulo counter in the counter family; the 0..99 free-running counter becomes a controllable resource.
Accepts start/stop/pause commands and a programmable terminal value.
Supports one-shot and auto-reload modes, a registered one-cycle done pulse and a saturating wrap count.
Sits between control logic (buttons/FSMs) and displays or timers that consume o_cnt.

---
 rtl/counter_ctrl_pkg.sv | 17 +
 rtl/counter_mod_n.sv | 27 ++
 rtl/counter_ctrl.sv | 109 ++++++++++
 tb/tb_counter_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared type definitions for the counter_ctrl run-mode sequencer.
// State codes are visible on o_state, so their values are fixed explicitly.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_ONESHOT = 1'b0,
    MODE_RELOAD  = 1'b1
  } mode_t;

endpackage

// File: rtl/counter_mod_n.sv
// Count register with synchronous clear and enable.
// Also provides a terminal-compare flag against the latched limit.
module counter_mod_n #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] lim,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == lim);

endmodule

// File: rtl/counter_ctrl.sv
// Run-mode sequencer for a programmable modulo counter: start/stop/pause,
// one-shot or auto-reload, registered done pulse and saturating wrap count.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int MAX_CNT = 99,
  parameter int CNT_W   = 7,
  parameter int WRAP_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_pause,
  input  logic              i_mode,
  input  logic [CNT_W-1:0]  i_limit,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_busy,
  output logic              o_done,
  output logic [WRAP_W-1:0] o_wrap_cnt,
  output logic [1:0]        o_state
);

  localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_CNT);

  state_t           state, state_n;
  mode_t            mode;
  logic [CNT_W-1:0] lim;
  logic [CNT_W-1:0] start_lim;
  logic             cnt_clr, cnt_en, tc;
  logic             relatch, done_n, wrap_inc;

  // Zero or out-of-range requests fall back to the full range.
  assign start_lim = (i_limit == '0 || i_limit > MAX_LIM) ? MAX_LIM : i_limit;

  counter_mod_n #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .lim   (lim),
    .cnt   (o_cnt),
    .tc    (tc)
  );

  // NOTE: every signal gets a default before the branches so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    relatch  = 1'b0;
    done_n   = 1'b0;
    wrap_inc = 1'b0;
    if (i_stop) begin
      state_n = ST_IDLE;
      cnt_clr = 1'b1;
    end else if (i_start) begin
      state_n = ST_RUN;
      cnt_clr = 1'b1;
      relatch = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (i_pause) begin
            state_n = ST_PAUSE;
          end else if (tc) begin
            done_n = 1'b1;
            if (mode == MODE_RELOAD) begin
              cnt_clr  = 1'b1;
              wrap_inc = 1'b1;
            end else begin
              state_n = ST_DONE;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_PAUSE: if (!i_pause) state_n = ST_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mode       <= MODE_ONESHOT;
      lim        <= MAX_LIM;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
      o_wrap_cnt <= '0;
    end else begin
      state  <= state_n;
      o_done <= done_n;
      o_busy <= (state_n == ST_RUN) || (state_n == ST_PAUSE);
      if (relatch) begin
        mode       <= mode_t'(i_mode);
        lim        <= start_lim;
        o_wrap_cnt <= '0;
      end else if (wrap_inc && o_wrap_cnt != '1) begin
        o_wrap_cnt <= o_wrap_cnt + WRAP_W'(1);
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios against fixed
// expectations, then randomized commands against a cycle-level reference model.
module tb_counter_ctrl;

  localparam int MAX_CNT = 99;
  localparam int CNT_W   = 7;
  localparam int WRAP_W  = 4;
  localparam int WRAP_MAX = (1 << WRAP_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_start = 1'b0, i_stop = 1'b0, i_pause = 1'b0, i_mode = 1'b0;
  logic [CNT_W-1:0]  i_limit = '0;
  logic [CNT_W-1:0]  o_cnt;
  logic              o_busy, o_done;
  logic [WRAP_W-1:0] o_wrap_cnt;
  logic [1:0]        o_state;

  int total = 0;
  int bad = 0;

  // Reference model, advanced once per rising edge from the sampled inputs.
  int m_state, m_cnt, m_lim, m_mode, m_wrap, m_done;

  counter_ctrl #(.MAX_CNT(MAX_CNT), .CNT_W(CNT_W), .WRAP_W(WRAP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_pause    (i_pause),
    .i_mode     (i_mode),
    .i_limit    (i_limit),
    .o_cnt      (o_cnt),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_wrap_cnt (o_wrap_cnt),
    .o_state    (o_state)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int req;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_lim = MAX_CNT; m_mode = 0; m_wrap = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (i_stop) begin
      m_state = 0; m_cnt = 0;
    end else if (i_start) begin
      req = int'(i_limit);
      m_lim = (req >= 1 && req <= MAX_CNT) ? req : MAX_CNT;
      m_mode = int'(i_mode);
      m_state = 1; m_cnt = 0; m_wrap = 0;
    end else if (m_state == 1) begin
      if (i_pause) m_state = 2;
      else if (m_cnt != m_lim) m_cnt++;
      else begin
        m_done = 1;
        if (m_mode == 1) begin
          m_cnt = 0;
          if (m_wrap < WRAP_MAX) m_wrap++;
        end else begin
          m_state = 3;
        end
      end
    end else if (m_state == 2) begin
      if (!i_pause) m_state = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic start_run(input logic mode, input int lim);
    i_mode = mode; i_limit = CNT_W'(lim); i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (o_cnt !== 0 || o_state !== 0 || o_busy !== 0 || o_done !== 0 || o_wrap_cnt !== 0) begin
      bad++;
      $display("FAIL reset_init: cnt=%0d state=%0d busy=%b done=%b wrap=%0d want all zero",
               o_cnt, o_state, o_busy, o_done, o_wrap_cnt);
    end
    start_run(1'b0, 50);
    repeat (40) tick();
    total++;
    if (o_cnt !== 40) begin
      bad++; $display("FAIL reset_pre_cnt: cnt=%0d want 40", o_cnt);
    end
    reset = 1'b1;
    tick();
    total++;
    if (o_cnt !== 0 || o_state !== 0 || o_busy !== 0 || o_done !== 0 || o_wrap_cnt !== 0) begin
      bad++;
      $display("FAIL reset_mid_run: cnt=%0d state=%0d busy=%b done=%b wrap=%0d want all zero",
               o_cnt, o_state, o_busy, o_done, o_wrap_cnt);
    end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    total++;
    if (o_state !== 0 || o_cnt !== 0) begin
      bad++; $display("FAIL reset_release: state=%0d cnt=%0d want 0/0", o_state, o_cnt);
    end
  endtask

  task automatic test_oneshot();
    start_run(1'b0, 5);
    i_limit = CNT_W'(2);  // must not affect the current run
    i_mode  = 1'b1;
    total++;
    if (o_cnt !== 0 || o_state !== 1 || o_busy !== 1) begin
      bad++; $display("FAIL oneshot_start: cnt=%0d state=%0d busy=%b want 0/1/1", o_cnt, o_state, o_busy);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (o_cnt !== CNT_W'(k) || o_state !== 1 || o_done !== 0) begin
        bad++; $display("FAIL oneshot_count: cnt=%0d state=%0d done=%b want %0d/1/0", o_cnt, o_state, o_done, k);
      end
    end
    tick();
    total++;
    if (o_state !== 3 || o_cnt !== 5 || o_done !== 1 || o_busy !== 0) begin
      bad++;
      $display("FAIL oneshot_done: state=%0d cnt=%0d done=%b busy=%b want 3/5/1/0", o_state, o_cnt, o_done, o_busy);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      total++;
      if (o_state !== 3 || o_cnt !== 5 || o_done !== 0) begin
        bad++; $display("FAIL oneshot_hold: state=%0d cnt=%0d done=%b want 3/5/0", o_state, o_cnt, o_done);
      end
    end
  endtask

  task automatic test_reload();
    start_run(1'b1, 3);
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++;
      if (o_cnt !== CNT_W'(i % 4) || o_done !== ((i % 4) == 0) || o_wrap_cnt !== WRAP_W'(i / 4) || o_state !== 1) begin
        bad++;
        $display("FAIL reload_cycle: i=%0d cnt=%0d done=%b wrap=%0d want %0d/%0d/%0d",
                 i, o_cnt, o_done, o_wrap_cnt, i % 4, (i % 4) == 0, i / 4);
      end
    end
    start_run(1'b1, 1);
    for (int i = 1; i <= 40; i++) begin
      tick();
      total++;
      if (o_wrap_cnt !== WRAP_W'((i / 2 > WRAP_MAX) ? WRAP_MAX : i / 2)) begin
        bad++; $display("FAIL reload_saturate: i=%0d wrap=%0d want %0d", i, o_wrap_cnt,
                        (i / 2 > WRAP_MAX) ? WRAP_MAX : i / 2);
      end
    end
  endtask

  task automatic test_illegal_limit();
    int lims[3] = '{0, 120, 127};
    foreach (lims[j]) begin
      start_run(1'b0, lims[j]);
      repeat (MAX_CNT) tick();
      total++;
      if (o_cnt !== CNT_W'(MAX_CNT) || o_state !== 1) begin
        bad++; $display("FAIL illegal_lim_top: req=%0d cnt=%0d state=%0d want %0d/1", lims[j], o_cnt, o_state, MAX_CNT);
      end
      tick();
      total++;
      if (o_state !== 3 || o_done !== 1 || o_cnt !== CNT_W'(MAX_CNT)) begin
        bad++; $display("FAIL illegal_lim_done: req=%0d state=%0d done=%b cnt=%0d want 3/1/%0d",
                        lims[j], o_state, o_done, o_cnt, MAX_CNT);
      end
    end
  endtask

  task automatic test_pause();
    start_run(1'b0, 50);
    repeat (10) tick();
    i_pause = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      total++;
      if (o_state !== 2 || o_cnt !== 10 || o_busy !== 1) begin
        bad++; $display("FAIL pause_hold: state=%0d cnt=%0d busy=%b want 2/10/1", o_state, o_cnt, o_busy);
      end
    end
    i_pause = 1'b0;
    tick();
    total++;
    if (o_state !== 1 || o_cnt !== 10) begin
      bad++; $display("FAIL pause_release: state=%0d cnt=%0d want 1/10", o_state, o_cnt);
    end
    tick();
    total++;
    if (o_cnt !== 11) begin
      bad++; $display("FAIL pause_resume: cnt=%0d want 11", o_cnt);
    end
  endtask

  task automatic test_simultaneous();
    i_start = 1'b1; i_stop = 1'b1;
    tick();
    i_start = 1'b0; i_stop = 1'b0;
    total++;
    if (o_state !== 0 || o_cnt !== 0 || o_busy !== 0) begin
      bad++; $display("FAIL start_stop: state=%0d cnt=%0d busy=%b want 0/0/0", o_state, o_cnt, o_busy);
    end
    start_run(1'b1, 4);
    repeat (9) tick();
    total++;
    if (o_cnt !== 4 || o_wrap_cnt !== 1) begin
      bad++; $display("FAIL pre_terminal: cnt=%0d wrap=%0d want 4/1", o_cnt, o_wrap_cnt);
    end
    start_run(1'b1, 4);
    total++;
    if (o_cnt !== 0 || o_wrap_cnt !== 0 || o_done !== 0 || o_state !== 1) begin
      bad++; $display("FAIL start_on_terminal: cnt=%0d wrap=%0d done=%b state=%0d want 0/0/0/1",
                      o_cnt, o_wrap_cnt, o_done, o_state);
    end
    start_run(1'b0, 2);
    repeat (2) tick();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    total++;
    if (o_done !== 0 || o_state !== 0 || o_cnt !== 0) begin
      bad++; $display("FAIL stop_on_terminal: done=%b state=%0d cnt=%0d want 0/0/0", o_done, o_state, o_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      reset   = ($urandom_range(0, 199) == 0);
      i_start = ($urandom_range(0, 29) == 0);
      i_stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) i_pause = ~i_pause;
      i_mode  = 1'($urandom);
      i_limit = ($urandom_range(0, 1) == 0) ? CNT_W'($urandom_range(0, 8)) : CNT_W'($urandom);
      tick();
      total++;
      if (o_state !== 2'(m_state) || o_cnt !== CNT_W'(m_cnt) || o_done !== 1'(m_done) ||
          o_wrap_cnt !== WRAP_W'(m_wrap) || o_busy !== (m_state == 1 || m_state == 2)) begin
        bad++;
        $display("FAIL random_n%0d: state=%0d cnt=%0d done=%b wrap=%0d busy=%b want %0d/%0d/%0d/%0d/%0d",
                 n, o_state, o_cnt, o_done, o_wrap_cnt, o_busy,
                 m_state, m_cnt, m_done, m_wrap, (m_state == 1 || m_state == 2));
      end
    end
    reset = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reload();
    test_illegal_limit();
    test_pause();
    test_simultaneous();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
